// File: rtl/gray_step_mon_pkg.sv
// Shared types and helpers for the Gray step monitor: lock FSM state and
// width-agnostic Gray/popcount functions (callers zero-extend and truncate).
package gray_step_mon_pkg;

   localparam int GSM_MAX_W = 32;

   typedef enum logic {
      UNLOCKED = 1'b0,
      LOCKED   = 1'b1
   } state_t;

   function automatic logic [GSM_MAX_W-1:0] g2b(input logic [GSM_MAX_W-1:0] gray);
      logic [GSM_MAX_W-1:0] bin;
      bin[GSM_MAX_W-1] = gray[GSM_MAX_W-1];
      for (int i = GSM_MAX_W - 2; i >= 0; i--) begin
         bin[i] = bin[i+1] ^ gray[i];
      end
      return bin;
   endfunction

   function automatic logic [6:0] popcnt(input logic [GSM_MAX_W-1:0] vec);
      logic [6:0] cnt;
      cnt = '0;
      for (int i = 0; i < GSM_MAX_W; i++) begin
         cnt = cnt + 7'(vec[i]);
      end
      return cnt;
   endfunction

endpackage

// File: rtl/gray_step_monitor_sync.sv
// W-bit two-flop synchronizer for an asynchronous Gray source; resets to zero.
// Only one bit changes per Gray step, so per-bit synchronization is coherent.
module gray_sync2 #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] meta_q, meta_d;
   logic [W-1:0] sync_q, sync_d;

   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/gray_step_monitor.sv
// Samples a Gray count, converts it to binary, flags legal +1 steps vs illegal jumps,
// and tracks lock state and a saturating error count. GRAY_STEP_MON_SYNC_EN adds a 2-flop input synchronizer.
module gray_step_monitor #(
   parameter int W        = 4,
   parameter int LOCK_CNT = 3,
   parameter int ERR_W    = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [W-1:0]     gray_in,
   input  logic             err_clr,
   output logic [W-1:0]     bin_out,
   output logic             step,
   output logic             err,
   output logic [ERR_W-1:0] err_cnt,
   output logic             locked
);
   import gray_step_mon_pkg::*;

   localparam int RUN_W = $clog2(LOCK_CNT + 1);

   logic [W-1:0] gray_s;

`ifdef GRAY_STEP_MON_SYNC_EN
   // g_cur only holds a real sample once the synchronizer pipe has filled.
   localparam int FILL = 3;
   gray_sync2 #(.W(W)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (gray_in),
      .q   (gray_s)
   );
`else
   localparam int FILL = 1;
   assign gray_s = gray_in;
`endif

   logic [W-1:0]     g_cur_q, g_cur_d;
   logic [W-1:0]     g_prev_q, g_prev_d;
   logic [1:0]       fill_q, fill_d;
   logic             primed_q, primed_d;
   state_t           state_q, state_d;
   logic [RUN_W-1:0] run_q, run_d;
   logic [W-1:0]     bin_q, bin_d;
   logic             step_q, step_d;
   logic             err_q, err_d;
   logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

   logic [W-1:0] diff, b_cur, b_prev;
   logic         cur_vld, is_step, is_err, classify;

   always_comb begin
      g_cur_d  = gray_s;
      g_prev_d = g_cur_q;

      cur_vld = (fill_q == 2'(FILL));
      fill_d  = cur_vld ? fill_q : fill_q + 2'd1;

      diff   = g_cur_q ^ g_prev_q;
      b_cur  = W'(g2b(GSM_MAX_W'(g_cur_q)));
      b_prev = W'(g2b(GSM_MAX_W'(g_prev_q)));

      is_step = (popcnt(GSM_MAX_W'(diff)) == 7'd1) && (b_cur == b_prev + W'(1));
      is_err  = (diff != '0) && !is_step;

      // The first real sample is only compared against reset junk, so it just primes.
      classify = cur_vld && primed_q;
      primed_d = primed_q || cur_vld;

      step_d = classify && is_step;
      err_d  = classify && is_err;
      bin_d  = b_cur;

      state_d = state_q;
      run_d   = run_q;
      case (state_q)
         UNLOCKED: begin
            if (step_d) begin
               run_d = run_q + RUN_W'(1);
               if (run_q == RUN_W'(LOCK_CNT - 1)) begin
                  state_d = LOCKED;
               end
            end else if (err_d) begin
               run_d = '0;
            end
         end
         LOCKED: begin
            if (err_d) begin
               state_d = UNLOCKED;
               run_d   = '0;
            end
         end
         default: begin
            state_d = UNLOCKED;
            run_d   = '0;
         end
      endcase

      err_cnt_d = err_cnt_q;
      if (err_clr) begin
         err_cnt_d = err_d ? ERR_W'(1) : '0;
      end else if (err_d && (err_cnt_q != '1)) begin
         err_cnt_d = err_cnt_q + ERR_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         g_cur_q   <= '0;
         g_prev_q  <= '0;
         fill_q    <= '0;
         primed_q  <= 1'b0;
         state_q   <= UNLOCKED;
         run_q     <= '0;
         bin_q     <= '0;
         step_q    <= 1'b0;
         err_q     <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         g_cur_q   <= g_cur_d;
         g_prev_q  <= g_prev_d;
         fill_q    <= fill_d;
         primed_q  <= primed_d;
         state_q   <= state_d;
         run_q     <= run_d;
         bin_q     <= bin_d;
         step_q    <= step_d;
         err_q     <= err_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign bin_out = bin_q;
   assign step    = step_q;
   assign err     = err_q;
   assign err_cnt = err_cnt_q;
   assign locked  = (state_q == LOCKED);

endmodule

// File: tb/tb_gray_step_monitor.sv
// Directed bench for gray_step_monitor with a per-cycle reference model built on
// a sample history and a Gray lookup table.
module tb_gray_step_monitor;

   localparam int W        = 4;
   localparam int LOCK_CNT = 3;
   localparam int ERR_W    = 2;
`ifdef GRAY_STEP_MON_SYNC_EN
   localparam int L = 3;
`else
   localparam int L = 1;
`endif

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic [W-1:0]     gray_in = '0;
   logic             err_clr = 1'b0;
   logic [W-1:0]     bin_out;
   logic             step;
   logic             err;
   logic [ERR_W-1:0] err_cnt;
   logic             locked;

   int checks = 0;
   int errors = 0;

   gray_step_monitor #(.W(W), .LOCK_CNT(LOCK_CNT), .ERR_W(ERR_W)) dut (
      .clk     (clk),
      .rst     (rst),
      .gray_in (gray_in),
      .err_clr (err_clr),
      .bin_out (bin_out),
      .step    (step),
      .err     (err),
      .err_cnt (err_cnt),
      .locked  (locked)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
      end
   endtask

   // Binary value of a Gray code by searching the forward code table.
   function automatic int m_g2b(input int g);
      for (int i = 0; i < (1 << W); i++) begin
         if ((i ^ (i >> 1)) == g) return i;
      end
      return -1;
   endfunction

   // Reference model: outputs after edge n depend on the sample taken at edge n-L.
   int hist[$];
   int m_bin, m_cnt, m_run;
   bit m_step, m_err, m_lock;

   initial begin
      int gs, n, cur, prv;
      bit cs, rs;
      m_bin = 0; m_cnt = 0; m_run = 0; m_step = 0; m_err = 0; m_lock = 0;
      forever begin
         @(posedge clk);
         gs = int'(gray_in);
         cs = err_clr;
         rs = rst;
         #1;
         if (!rs) begin
            hist.delete();
            m_bin = 0; m_cnt = 0; m_run = 0; m_step = 0; m_err = 0; m_lock = 0;
         end else begin
            hist.push_back(gs);
            n = hist.size();
            m_step = 0;
            m_err  = 0;
            m_bin  = (n - L >= 1) ? m_g2b(hist[n-L-1]) : 0;
            if (n - L >= 2) begin
               cur = hist[n-L-1];
               prv = hist[n-L-2];
               if (cur != prv) begin
                  if ($countones(cur ^ prv) == 1 && m_g2b(cur) == (m_g2b(prv) + 1) % (1 << W))
                     m_step = 1;
                  else
                     m_err = 1;
               end
            end
            if (m_step && !m_lock) begin
               m_run++;
               if (m_run >= LOCK_CNT) m_lock = 1;
            end
            if (m_err) begin
               m_run  = 0;
               m_lock = 0;
            end
            if (cs) m_cnt = m_err ? 1 : 0;
            else if (m_err && m_cnt < (1 << ERR_W) - 1) m_cnt++;
         end
         chk("model_bin_out", int'(bin_out), m_bin);
         chk("model_step",    int'(step),    int'(m_step));
         chk("model_err",     int'(err),     int'(m_err));
         chk("model_err_cnt", int'(err_cnt), m_cnt);
         chk("model_locked",  int'(locked),  int'(m_lock));
      end
   end

   // Present one Gray value; err_clr (if set) lands on the edge that classifies it.
   // Returns at the negedge where that value's outputs are visible.
   task automatic apply(input logic [W-1:0] g, input logic clr);
      gray_in = g;
      repeat (L) @(negedge clk);
      err_clr = clr;
      @(negedge clk);
      err_clr = 1'b0;
   endtask

   initial begin
      gray_in = 4'b0110;
      repeat (2) @(negedge clk);
      chk("rst_bin_out", int'(bin_out), 0);
      chk("rst_step",    int'(step),    0);
      chk("rst_err",     int'(err),     0);
      chk("rst_err_cnt", int'(err_cnt), 0);
      chk("rst_locked",  int'(locked),  0);

      rst = 1'b1;
      repeat (L + 3) @(negedge clk);
      chk("prime_bin_out", int'(bin_out), 4);
      chk("prime_err",     int'(err),     0);
      chk("prime_step",    int'(step),    0);
      chk("prime_err_cnt", int'(err_cnt), 0);
      chk("prime_locked",  int'(locked),  0);

      // Restart from zero so the counter sequence begins at 0000.
      rst = 1'b0;
      gray_in = 4'b0000;
      @(negedge clk);
      rst = 1'b1;
      repeat (L + 3) @(negedge clk);

      apply(4'b0001, 1'b0);
      chk("seq1_step", int'(step), 1);
      chk("seq1_locked", int'(locked), 0);
      apply(4'b0011, 1'b0);
      chk("seq2_step", int'(step), 1);
      chk("seq2_locked", int'(locked), 0);
      apply(4'b0010, 1'b0);
      chk("seq3_step", int'(step), 1);
      chk("seq3_locked", int'(locked), 1);
      chk("seq3_bin", int'(bin_out), 3);

      for (int b = 4; b <= 14; b++) begin
         apply(4'(b ^ (b >> 1)), 1'b0);
      end
      chk("wrap14_bin", int'(bin_out), 14);
      apply(4'b1000, 1'b0);
      chk("wrap15_bin", int'(bin_out), 15);
      chk("wrap15_step", int'(step), 1);
      apply(4'b0000, 1'b0);
      chk("wrap0_bin", int'(bin_out), 0);
      chk("wrap0_step", int'(step), 1);
      chk("wrap0_err", int'(err), 0);
      chk("wrap0_locked", int'(locked), 1);

      apply(4'b0011, 1'b0);
      chk("jump_err", int'(err), 1);
      chk("jump_err_cnt", int'(err_cnt), 1);
      chk("jump_locked", int'(locked), 0);
      apply(4'b0001, 1'b0);
      chk("back_err", int'(err), 1);
      chk("back_err_cnt", int'(err_cnt), 2);

      apply(4'b0011, 1'b0);
      apply(4'b0010, 1'b0);
      apply(4'b0110, 1'b0);
      chk("relock_locked", int'(locked), 1);
      chk("relock_err_cnt", int'(err_cnt), 2);

      #2 rst = 1'b0;
      #1;
      chk("mid_rst_bin_out", int'(bin_out), 0);
      chk("mid_rst_step",    int'(step),    0);
      chk("mid_rst_err",     int'(err),     0);
      chk("mid_rst_err_cnt", int'(err_cnt), 0);
      chk("mid_rst_locked",  int'(locked),  0);
      gray_in = 4'b1111;
      @(negedge clk);
      rst = 1'b1;
      repeat (L + 3) @(negedge clk);
      chk("post_rst_err", int'(err), 0);
      chk("post_rst_bin", int'(bin_out), 10);
      chk("post_rst_err_cnt", int'(err_cnt), 0);

      gray_in = 4'b1110;
      repeat (L) @(negedge clk);
      chk("lat_early_step", int'(step), 0);
      @(negedge clk);
      chk("lat_step", int'(step), 1);
      chk("lat_bin", int'(bin_out), 11);

      for (int i = 0; i < 5; i++) begin
         apply((i % 2 == 0) ? 4'b0001 : 4'b1110, 1'b0);
         chk("sat_err", int'(err), 1);
      end
      chk("sat_err_cnt", int'(err_cnt), 3);
      apply(4'b1110, 1'b1);
      chk("clr_err_pulse", int'(err), 1);
      chk("clr_same_cycle_cnt", int'(err_cnt), 1);
      apply(4'b1110, 1'b1);
      chk("clr_only_cnt", int'(err_cnt), 0);

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
